// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI mode-0 master sequencer (SCLK/CS_n, load/shift pulses, MISO sample).
// Optional macro SPI_CS_GUARD_EN adds a CS hold state before DONE and a post-DONE start lockout.
module spi_master_ctrl #(
    parameter int WIDTH   = 32,
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  logic i_miso,
    output logic o_sclk,
    output logic o_cs_n,
    output logic o_load_en,
    output logic o_sh_en,
    output logic o_miso_bit,
    output logic o_busy,
    output logic o_done
);
    localparam int DW = $clog2(CLK_DIV) + 1;
    localparam int BW = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, GUARD, DONE} state_t;

    state_t          state, state_n;
    logic [DW-1:0]   div;
    logic [BW-1:0]   bit_cnt;
    logic            last, start_ok, busy_n;

    assign last = div == DW'(CLK_DIV - 1);

`ifdef SPI_CS_GUARD_EN
    logic [DW-1:0] lock;
    assign start_ok = lock == '0;
    // Minimum CS-high time: block new starts for CLK_DIV cycles after DONE
    always_ff @(posedge i_clk)
        if (i_rst) lock <= '0;
        else lock <= (state == DONE) ? DW'(CLK_DIV) : (lock != '0 ? lock - 1'b1 : '0);
`else
    assign start_ok = 1'b1;
`endif

    // Next-state logic; each timed phase lasts CLK_DIV cycles
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = (i_start && start_ok) ? LEAD : IDLE;
            LEAD:    state_n = last ? HIGH : LEAD;
            HIGH:    state_n = last ? LOW : HIGH;
`ifdef SPI_CS_GUARD_EN
            LOW:     state_n = !last ? LOW : (bit_cnt == BW'(WIDTH - 1)) ? GUARD : HIGH;
            GUARD:   state_n = last ? DONE : GUARD;
`else
            LOW:     state_n = !last ? LOW : (bit_cnt == BW'(WIDTH - 1)) ? DONE : HIGH;
`endif
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        busy_n = state_n inside {LEAD, HIGH, LOW, GUARD};
    end

    // State, phase divider (restarts on every state change) and bit counter
    always_ff @(posedge i_clk)
        if (i_rst) begin
            state   <= IDLE;
            div     <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_n;
            div     <= (state_n != state || state == IDLE) ? '0 : div + 1'b1;
            bit_cnt <= (state == IDLE) ? '0 : (state == LOW && state_n == HIGH) ? bit_cnt + 1'b1 : bit_cnt;
        end

    // Registered outputs decoded from the upcoming state so they align with it
    always_ff @(posedge i_clk)
        if (i_rst) begin
            o_sclk     <= 1'b0;
            o_cs_n     <= 1'b1;
            o_load_en  <= 1'b0;
            o_sh_en    <= 1'b0;
            o_miso_bit <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            o_sclk     <= state_n == HIGH;
            o_cs_n     <= !busy_n;
            o_busy     <= busy_n;
            o_load_en  <= state == IDLE && state_n == LEAD;
            o_sh_en    <= state == HIGH && state_n == LOW;
            o_miso_bit <= (state == HIGH && state_n == LOW) ? i_miso : o_miso_bit;
            o_done     <= state_n == DONE;
        end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: randomized cycle-accurate check of spi_master_ctrl against a timeline model.
module tb_spi_master_ctrl;
    localparam int W  = 8;
    localparam int CD = 2;
`ifdef SPI_CS_GUARD_EN
    localparam int G = CD;
`else
    localparam int G = 0;
`endif
    localparam int L = CD * (2 * W + 1) + G;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, miso = 1'b0;
    logic sclk, cs_n, load_en, sh_en, miso_bit, busy, done;
    logic [W-1:0] sr, tx, pat, exp_rx;
    int vecs = 0, errs = 0;

    always #5 clk = ~clk;

    spi_master_ctrl #(.WIDTH(W), .CLK_DIV(CD)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_miso(miso),
        .o_sclk(sclk), .o_cs_n(cs_n), .o_load_en(load_en), .o_sh_en(sh_en),
        .o_miso_bit(miso_bit), .o_busy(busy), .o_done(done)
    );

    // Datapath shift register driven by the sequencer pulses
    always @(posedge clk)
        if (load_en) sr <= tx;
        else if (sh_en) sr <= {sr[W-2:0], miso_bit};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        int k, m, t0, nx, ndone, rst_left, mode, bd;
        bit act, inx, run, idle, just_rst, did_rst;
        t0 = 0; nx = 0; ndone = 0; rst_left = 0; mode = 0;
        act = 0; just_rst = 1; did_rst = 0;
        tx = '0; pat = '0; exp_rx = '0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            k    = act ? c - t0 - 1 : -1;
            m    = k - CD;
            inx  = act && k >= 0 && k <= L;
            run  = inx && k >= CD && k < CD * (2 * W + 1);
            idle = !act || k > L + G;
            check("load_en", load_en, inx && k == 0);
            check("busy", busy, inx && k < L);
            check("cs_n", cs_n, !(inx && k < L));
            check("sclk", sclk, run && (m % (2 * CD)) < CD);
            check("sh_en", sh_en, run && (m % (2 * CD)) == CD);
            check("done", done, inx && k == L);
            if (run && (m % (2 * CD)) == CD) check("miso_bit", miso_bit, exp_rx[W-1-m/(2*CD)]);
            if (just_rst) check("miso_bit_rst", miso_bit, 0);
            if (inx && k == L) begin
                check("rx_word", sr, exp_rx);
                ndone++;
            end
            just_rst = 0;
            if (!did_rst && nx == 5 && inx && k == 20) begin
                rst_left = 3;
                did_rst = 1;
            end
            rst = (c < 3) || rst_left > 0;
            if (rst_left > 0) rst_left--;
            start = idle ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
            if (inx && k == L) start = 1'b1;
            if (act && k == L + 1 && nx % 2 == 0) start = 1'b1;
            if (act && k == L + 1 + G && nx % 3 == 1) start = 1'b1;
            if (mode == 0) miso = sr[W-1];
            else if (inx && k < CD * (2 * W + 1)) begin
                bd = (k < CD) ? 0 : m / (2 * CD) + (((m % (2 * CD)) >= CD) ? 1 : 0);
                if (bd < W) miso = pat[W-1-bd];
            end
            if (rst) begin
                act = 0;
                just_rst = 1;
            end else if (start && idle) begin
                t0 = c;
                act = 1;
                nx++;
                mode = (nx == 1) ? 0 : (nx == 2) ? 2 : (nx == 3) ? 3 : int'($urandom_range(0, 3));
                tx = (nx == 1) ? 8'hA5 : W'($urandom);
                pat = (mode == 2) ? '1 : (mode == 3) ? 8'hB2 : W'($urandom);
                exp_rx = (mode == 0) ? tx : pat;
                if (mode == 0) miso = sr[W-1];
                else miso = pat[W-1];
            end
        end
        check("transfers_done", ndone >= 20, 1);
        check("reset_injected", did_rst, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
